sp: RTL and testbench

- Stack-pointer register for the CPU datapath.
- Holds a 32-bit pointer that can be loaded directly, incremented, decremented or held, under a 2-bit drive code from the control unit.
- The current pointer is driven continuously to memory-address logic on SPOutput.
- Purely synchronous single-register block with a next-value mux and adder/subtractor.

---
 rtl/sp.sv | 58 +++++
 tb/tb_sp.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/sp.sv
// ---------------------------------------------------------------------------
// sp: stack-pointer register for the CPU datapath.
//
// Holds one DATA_WIDTH-bit pointer that is held, incremented, decremented or
// loaded each rising clock edge under a 2-bit drive code. The current pointer
// is always presented on SPOutput straight from the register.
//
// Ports:
//   clk       in   1           system clock, rising-edge active
//   rst       in   1           synchronous active-high reset to RESET_VALUE
//   SPSet     in   DATA_WIDTH  load value, used only when SPDrive = 2'b11
//   SPDrive   in   2           00 hold, 01 increment, 10 decrement, 11 load
//   SPOutput  out  DATA_WIDTH  current stack pointer (registered)
// ---------------------------------------------------------------------------
module sp #(
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0]      STEP        = DATA_WIDTH'(1),
  parameter logic [DATA_WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] SPSet,
  input  logic [1:0]            SPDrive,
  output logic [DATA_WIDTH-1:0] SPOutput
);

  localparam logic [1:0] DRV_HOLD = 2'b00;
  localparam logic [1:0] DRV_INC  = 2'b01;
  localparam logic [1:0] DRV_DEC  = 2'b10;
  localparam logic [1:0] DRV_LOAD = 2'b11;

  logic [DATA_WIDTH-1:0] r_sp;
  logic [DATA_WIDTH-1:0] w_sp_next;

  // Next-value mux; add/subtract wrap modulo 2^DATA_WIDTH with no flags.
  // SPSet only reaches the mux on a load, so it cannot disturb other codes.
  always_comb begin
    w_sp_next = r_sp;
    case (SPDrive)
      DRV_HOLD: w_sp_next = r_sp;
      DRV_INC:  w_sp_next = r_sp + STEP;
      DRV_DEC:  w_sp_next = r_sp - STEP;
      DRV_LOAD: w_sp_next = SPSet;
    endcase
  end

  // Pointer register; reset overrides any pending drive code.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= RESET_VALUE;
    end else begin
      r_sp <= w_sp_next;
    end
  end

  assign SPOutput = r_sp;

endmodule

// File: tb/tb_sp.sv
// ---------------------------------------------------------------------------
// tb_sp: self-checking bench for the sp stack-pointer register.
// A behavioural model tracks the expected pointer with plain modular
// arithmetic; a compare process checks SPOutput against it every cycle, and
// the directed sequence pins the model with literal expectations.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sp;

  localparam int unsigned DW = 32;
  localparam longint unsigned MODULUS = 64'h1_0000_0000;

  logic          clk;
  logic          rst;
  logic [DW-1:0] SPSet;
  logic [1:0]    SPDrive;
  logic [DW-1:0] SPOutput;

  int n_checks;
  int n_fail;

  sp #(.DATA_WIDTH(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .SPSet    (SPSet),
    .SPDrive  (SPDrive),
    .SPOutput (SPOutput)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: pointer as an integer taken modulo 2^DW.
  longint unsigned m_sp;
  bit              m_valid;

  initial begin
    m_sp    = 0;
    m_valid = 1'b0;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_sp    <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      case (SPDrive)
        2'd0: m_sp <= m_sp;
        2'd1: m_sp <= (m_sp + 1) % MODULUS;
        2'd2: m_sp <= (m_sp + MODULUS - 1) % MODULUS;
        2'd3: m_sp <= longint'(SPSet);
      endcase
    end
  end

  // Per-cycle comparison once the power-up value has been cleared by reset.
  always @(negedge clk) begin
    if (m_valid) check("model", SPOutput, DW'(m_sp));
  end

  // Drive one command away from the edge, then settle just after the edge.
  task automatic step(input logic r, input logic [1:0] drv, input logic [DW-1:0] set);
    @(negedge clk);
    rst     = r;
    SPDrive = drv;
    SPSet   = set;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    SPDrive  = 2'b00;
    SPSet    = '0;

    // Reset wins over a simultaneous load.
    step(1'b1, 2'b11, DW'(1234));  check("reset_over_load", SPOutput, 32'd0);

    // Load / hold.
    step(1'b0, 2'b00, DW'(0));     check("hold_after_reset", SPOutput, 32'd0);
    step(1'b0, 2'b11, DW'(5791));  check("load_5791", SPOutput, 32'd5791);
    step(1'b0, 2'b00, DW'(7894));  check("hold_ignores_set", SPOutput, 32'd5791);

    // Increment / decrement.
    step(1'b0, 2'b01, DW'(0));     check("inc_5792", SPOutput, 32'd5792);
    step(1'b0, 2'b01, DW'(0));     check("inc_5793", SPOutput, 32'd5793);
    step(1'b0, 2'b10, DW'(0));     check("dec_5792", SPOutput, 32'd5792);
    step(1'b0, 2'b00, DW'(0));     check("hold_5792", SPOutput, 32'd5792);

    // Reset mid-operation discards the increment; next increment starts at 0.
    step(1'b1, 2'b01, DW'(0));     check("reset_mid_inc", SPOutput, 32'd0);
    step(1'b0, 2'b01, DW'(0));     check("inc_after_reset", SPOutput, 32'd1);

    // Wrap-around both ways.
    step(1'b0, 2'b11, 32'hFFFF_FFFF); check("load_max", SPOutput, 32'hFFFF_FFFF);
    step(1'b0, 2'b01, DW'(0));        check("inc_wrap", SPOutput, 32'h0000_0000);
    step(1'b0, 2'b11, 32'h0000_0000); check("load_zero", SPOutput, 32'h0000_0000);
    step(1'b0, 2'b10, DW'(0));        check("dec_wrap", SPOutput, 32'hFFFF_FFFF);

    // Back-to-back loads.
    step(1'b0, 2'b11, DW'(100));   check("b2b_load_100", SPOutput, 32'd100);
    step(1'b0, 2'b11, DW'(200));   check("b2b_load_200", SPOutput, 32'd200);

    // Accumulation while increment is held.
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 2'b01, $urandom);
      check("inc_run", SPOutput, DW'(200 + i));
    end

    // Randomised traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 3000; i++) begin
      logic          r;
      logic [1:0]    drv;
      logic [DW-1:0] set;
      r   = ($urandom_range(0, 49) == 0);
      drv = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       set = 32'hFFFF_FFFF - DW'($urandom_range(0, 3));
        1:       set = DW'($urandom_range(0, 3));
        default: set = DW'($urandom);
      endcase
      step(r, drv, set);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
